control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  system clock; all state changes occur on the rising edge.
REQ-002 clr  in  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-003 ir  in  32  instruction register contents from Datapath2; opcode is ir[31:27].
REQ-004 con_ff  in  1  branch condition flip-flop output (ConOtp) from Datapath2.
REQ-005 PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus-source enables.
REQ-006 MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, CONin, OutportIn, Rin  out  1 each  register load enables.
REQ-007 Gra, Grb, Grc, Rout  out  1 each  register-file field selects and register-file drive enable.
REQ-008 Read, Write  out  1 each  memory strobes.
REQ-009 ALU_Control  out  5  ALU operation code; 5'd0 when no ALU operation is active.
REQ-010 run  out  1  high while fetching or executing; low in RESET and HALT.

Function
REQ-011 States SHALL be RESET, T0..T7 and HALT; each T-state lasts exactly one clk cycle.
REQ-012 Outputs SHALL be a combinational decode of the state register and ir[31:27]; every output not listed for a state is 0.
REQ-013 Fetch: T0 asserts PCout, MARin, Zin, ALU_Control=INC(12); T1 asserts Zlowout, PCin, Read, MDRin; T2 asserts MDRout, IRin.
REQ-014 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01011, andi 01100, ori 01101, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011.
REQ-015 add/sub/and/or: T3 Grb+Rout+Yin; T4 Grc+Rout+Zin+ALU op; T5 Zlowout+Gra+Rin; then T0.
REQ-016 addi/andi/ori: T3 Grb+Rout+Yin; T4 Cout+Zin+ALU op (ADD/AND/OR); T5 Zlowout+Gra+Rin; then T0.
REQ-017 ldi: T3 Grb+BAout+Yin; T4 Cout+Zin+ADD; T5 Zlowout+Gra+Rin; then T0.
REQ-018 ld: T3 through T4 as ldi; T5 Zlowout+MARin; T6 Read+MDRin; T7 MDRout+Gra+Rin; then T0.
REQ-019 st: T3 through T4 as ldi; T5 Zlowout+MARin; T6 Gra+Rout+MDRin; T7 Write; then T0.
REQ-020 br: T3 Gra+Rout+CONin; T4 PCout+Yin; T5 Cout+Zin+ADD; T6 Zlowout+PCin only if con_ff=1 (otherwise all outputs 0); then T0.
REQ-021 jr: T3 Gra+Rout+PCin; then T0. jal: T3 PCout+Grb+Rin; T4 Gra+Rout+PCin; then T0.
REQ-022 in: T3 InPortout+Gra+Rin. out: T3 Gra+Rout+OutportIn. mfhi: T3 HIout+Gra+Rin. mflo: T3 LOout+Gra+Rin. All four then go to T0.
REQ-023 nop and any undefined opcode: T2 goes directly to T0.
REQ-024 halt: T2 goes to HALT; HALT holds with all outputs 0 and run=0 until reset.
REQ-025 ALU codes: ADD=5'd2, SUB=5'd3, AND=5'd4, OR=5'd5, INC=5'd12.
REQ-026 Each cycle SHALL assert at most one bus source and at most one of Read/Write.

Reset
REQ-027 clr=0 at a rising edge forces RESET in any state, including mid-instruction; the aborted instruction produces no further strobes.
REQ-028 In RESET all outputs are 0 and run=0; the first rising edge with clr=1 moves to T0.

Structure
REQ-029 Package cpu_defs SHALL hold the state encoding, opcode constants and ALU codes.
REQ-030 One sub-module, control_decode, SHALL be combinational (state, opcode, con_ff) -> control outputs; control_unit holds only the state register and next-state logic.

Verification
REQ-031 Reset: hold clr=0 for 3 cycles -> run=0, all outputs 0; release -> T0 on the next edge, with PCout=MARin=Zin=1 and ALU_Control=12.
REQ-032 Branch taken: ir=32'h9B000019, con_ff=1 -> T6 asserts Zlowout and PCin; the next cycle is T0.
REQ-033 Branch not taken: same ir, con_ff=0 -> T6 has all outputs 0; the next cycle is T0.
REQ-034 ld: ir=32'h00800045 -> T6 Read=MDRin=1; T7 MDRout=Gra=Rin=1; the instruction takes 8 cycles total (T0..T7).
REQ-035 halt: ir=32'hD8000000 -> after T2, state HALT, run=0, outputs stay 0 for 10 cycles; clr=0 -> RESET.
REQ-036 Mid-operation reset: st with clr=0 during T6 -> no Write asserted; RESET on the next cycle.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the control unit: state encoding, opcodes, ALU codes, control word.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package cpu_defs;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LD   = 5'b00000;
    localparam opcode_t OP_LDI  = 5'b00001;
    localparam opcode_t OP_ST   = 5'b00010;
    localparam opcode_t OP_ADD  = 5'b00011;
    localparam opcode_t OP_SUB  = 5'b00100;
    localparam opcode_t OP_AND  = 5'b00101;
    localparam opcode_t OP_OR   = 5'b00110;
    localparam opcode_t OP_ADDI = 5'b01011;
    localparam opcode_t OP_ANDI = 5'b01100;
    localparam opcode_t OP_ORI  = 5'b01101;
    localparam opcode_t OP_BR   = 5'b10011;
    localparam opcode_t OP_JR   = 5'b10100;
    localparam opcode_t OP_JAL  = 5'b10101;
    localparam opcode_t OP_IN   = 5'b10110;
    localparam opcode_t OP_OUT  = 5'b10111;
    localparam opcode_t OP_MFHI = 5'b11000;
    localparam opcode_t OP_MFLO = 5'b11001;
    localparam opcode_t OP_NOP  = 5'b11010;
    localparam opcode_t OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUB  = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_INC  = 5'd12;

    // Full control word produced by the decoder each cycle.
    typedef struct packed {
        logic       run;
        logic [4:0] alu_control;
        logic       pc_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       mdr_out;
        logic       hi_out;
        logic       lo_out;
        logic       inport_out;
        logic       c_out;
        logic       ba_out;
        logic       mar_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       pc_in;
        logic       hi_in;
        logic       lo_in;
        logic       con_in;
        logic       outport_in;
        logic       r_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_out;
        logic       read;
        logic       write;
    } ctrl_t;

    // Final T-state of each instruction; nop and undefined opcodes end at T2.
    function automatic state_t last_state(input opcode_t op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  return ST_T5;
            OP_LD, OP_ST:                      return ST_T7;
            OP_BR:                             return ST_T6;
            OP_JAL:                            return ST_T4;
            OP_JR, OP_IN, OP_OUT,
            OP_MFHI, OP_MFLO:                  return ST_T3;
            default:                           return ST_T2;
        endcase
    endfunction

    // ALU operation used in the execute step of arithmetic/logic instructions.
    function automatic logic [4:0] alu_code(input opcode_t op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            default:         return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational decode of (state, opcode, con_ff) into the datapath control word.
// Latency: zero cycles (pure combinational).
// Backpressure: none; outputs follow inputs every cycle.
// Ports: i_state current FSM state, i_opcode ir[31:27], i_con_ff branch condition, o_ctrl control word.
module control_decode
    import cpu_defs::*;
(
    input  state_t  i_state,
    input  opcode_t i_opcode,
    input  logic    i_con_ff,
    output ctrl_t   o_ctrl
);

    always_comb begin
        o_ctrl     = '0;
        o_ctrl.run = (i_state != ST_RESET) && (i_state != ST_HALT);

        case (i_state)
            ST_T0: begin
                o_ctrl.pc_out      = 1'b1;
                o_ctrl.mar_in      = 1'b1;
                o_ctrl.z_in        = 1'b1;
                o_ctrl.alu_control = ALU_INC;
            end
            ST_T1: begin
                o_ctrl.zlow_out = 1'b1;
                o_ctrl.pc_in    = 1'b1;
                o_ctrl.read     = 1'b1;
                o_ctrl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                o_ctrl.mdr_out = 1'b1;
                o_ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (i_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        o_ctrl.grb   = 1'b1;
                        o_ctrl.r_out = 1'b1;
                        o_ctrl.y_in  = 1'b1;
                    end
                    // Base-address path: BAout reads Rb but forces 0 when Rb is R0.
                    OP_LDI, OP_LD, OP_ST: begin
                        o_ctrl.grb    = 1'b1;
                        o_ctrl.ba_out = 1'b1;
                        o_ctrl.y_in   = 1'b1;
                    end
                    OP_BR: begin
                        o_ctrl.gra    = 1'b1;
                        o_ctrl.r_out  = 1'b1;
                        o_ctrl.con_in = 1'b1;
                    end
                    OP_JR: begin
                        o_ctrl.gra   = 1'b1;
                        o_ctrl.r_out = 1'b1;
                        o_ctrl.pc_in = 1'b1;
                    end
                    // Link register (Rb) captures the return PC first.
                    OP_JAL: begin
                        o_ctrl.pc_out = 1'b1;
                        o_ctrl.grb    = 1'b1;
                        o_ctrl.r_in   = 1'b1;
                    end
                    OP_IN: begin
                        o_ctrl.inport_out = 1'b1;
                        o_ctrl.gra        = 1'b1;
                        o_ctrl.r_in       = 1'b1;
                    end
                    OP_OUT: begin
                        o_ctrl.gra        = 1'b1;
                        o_ctrl.r_out      = 1'b1;
                        o_ctrl.outport_in = 1'b1;
                    end
                    OP_MFHI: begin
                        o_ctrl.hi_out = 1'b1;
                        o_ctrl.gra    = 1'b1;
                        o_ctrl.r_in   = 1'b1;
                    end
                    OP_MFLO: begin
                        o_ctrl.lo_out = 1'b1;
                        o_ctrl.gra    = 1'b1;
                        o_ctrl.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (i_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        o_ctrl.grc         = 1'b1;
                        o_ctrl.r_out       = 1'b1;
                        o_ctrl.z_in        = 1'b1;
                        o_ctrl.alu_control = alu_code(i_opcode);
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        o_ctrl.c_out       = 1'b1;
                        o_ctrl.z_in        = 1'b1;
                        o_ctrl.alu_control = alu_code(i_opcode);
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        o_ctrl.c_out       = 1'b1;
                        o_ctrl.z_in        = 1'b1;
                        o_ctrl.alu_control = ALU_ADD;
                    end
                    OP_BR: begin
                        o_ctrl.pc_out = 1'b1;
                        o_ctrl.y_in   = 1'b1;
                    end
                    OP_JAL: begin
                        o_ctrl.gra   = 1'b1;
                        o_ctrl.r_out = 1'b1;
                        o_ctrl.pc_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (i_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        o_ctrl.zlow_out = 1'b1;
                        o_ctrl.gra      = 1'b1;
                        o_ctrl.r_in     = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        o_ctrl.zlow_out = 1'b1;
                        o_ctrl.mar_in   = 1'b1;
                    end
                    OP_BR: begin
                        o_ctrl.c_out       = 1'b1;
                        o_ctrl.z_in        = 1'b1;
                        o_ctrl.alu_control = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (i_opcode)
                    OP_LD: begin
                        o_ctrl.read   = 1'b1;
                        o_ctrl.mdr_in = 1'b1;
                    end
                    OP_ST: begin
                        o_ctrl.gra    = 1'b1;
                        o_ctrl.r_out  = 1'b1;
                        o_ctrl.mdr_in = 1'b1;
                    end
                    // Untaken branch leaves this cycle completely idle.
                    OP_BR: begin
                        o_ctrl.zlow_out = i_con_ff;
                        o_ctrl.pc_in    = i_con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (i_opcode)
                    OP_LD: begin
                        o_ctrl.mdr_out = 1'b1;
                        o_ctrl.gra     = 1'b1;
                        o_ctrl.r_in    = 1'b1;
                    end
                    OP_ST: begin
                        o_ctrl.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: RESET/T0..T7/HALT state machine driving the datapath control strobes.
// Latency: state advances one T-step per clk; outputs are combinational from state and opcode.
// Backpressure: none; every T-state lasts exactly one cycle, clr=0 aborts to RESET at the next edge.
// Ports: clk, clr (sync active-low), ir/con_ff from the datapath; bus-source enables, register
//        load enables, register-file selects, memory strobes, ALU_Control and run to the datapath.
module control_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        PCin,
    output logic        HIin,
    output logic        LOin,
    output logic        CONin,
    output logic        OutportIn,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  ALU_Control,
    output logic        run
);

    state_t  r_state;
    state_t  w_next_state;
    opcode_t w_opcode;
    ctrl_t   w_ctrl;
    logic    w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_unused_ir = ^ir[26:0];

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // T2 onward: step through T-states until the opcode's final state, then refetch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: w_next_state = ST_T0;
            ST_T0:    w_next_state = ST_T1;
            ST_T1:    w_next_state = ST_T2;
            ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (r_state == ST_T2 && w_opcode == OP_HALT) begin
                    w_next_state = ST_HALT;
                end else if (r_state == ST_T7 || r_state == last_state(w_opcode)) begin
                    w_next_state = ST_T0;
                end else begin
                    w_next_state = state_t'(r_state + 4'd1);
                end
            end
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_RESET;
        endcase
    end

    control_decode u_decode (
        .i_state  (r_state),
        .i_opcode (w_opcode),
        .i_con_ff (con_ff),
        .o_ctrl   (w_ctrl)
    );

    assign PCout       = w_ctrl.pc_out;
    assign Zlowout     = w_ctrl.zlow_out;
    assign Zhighout    = w_ctrl.zhigh_out;
    assign MDRout      = w_ctrl.mdr_out;
    assign HIout       = w_ctrl.hi_out;
    assign LOout       = w_ctrl.lo_out;
    assign InPortout   = w_ctrl.inport_out;
    assign Cout        = w_ctrl.c_out;
    assign BAout       = w_ctrl.ba_out;
    assign MARin       = w_ctrl.mar_in;
    assign MDRin       = w_ctrl.mdr_in;
    assign IRin        = w_ctrl.ir_in;
    assign Yin         = w_ctrl.y_in;
    assign Zin         = w_ctrl.z_in;
    assign PCin        = w_ctrl.pc_in;
    assign HIin        = w_ctrl.hi_in;
    assign LOin        = w_ctrl.lo_in;
    assign CONin       = w_ctrl.con_in;
    assign OutportIn   = w_ctrl.outport_in;
    assign Rin         = w_ctrl.r_in;
    assign Gra         = w_ctrl.gra;
    assign Grb         = w_ctrl.grb;
    assign Grc         = w_ctrl.grc;
    assign Rout        = w_ctrl.r_out;
    assign Read        = w_ctrl.read;
    assign Write       = w_ctrl.write;
    assign ALU_Control = w_ctrl.alu_control;
    assign run         = w_ctrl.run;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit against a per-instruction step-list model.
// Latency: one control step per clk; outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        con_ff = 1'b0;

    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic MARin, MDRin, IRin, Yin, Zin, PCin, HIin, LOin, CONin, OutportIn, Rin;
    logic Gra, Grb, Grc, Rout, Read, Write, run;
    logic [4:0] ALU_Control;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .PCin(PCin),
        .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutportIn(OutportIn), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rout(Rout), .Read(Read), .Write(Write),
        .ALU_Control(ALU_Control), .run(run)
    );

    // Signal bit positions in the observed/expected mask.
    localparam logic [25:0] M_PCOUT   = 26'd1 << 0;
    localparam logic [25:0] M_ZLOW    = 26'd1 << 1;
    localparam logic [25:0] M_ZHIGH   = 26'd1 << 2;
    localparam logic [25:0] M_MDROUT  = 26'd1 << 3;
    localparam logic [25:0] M_HIOUT   = 26'd1 << 4;
    localparam logic [25:0] M_LOOUT   = 26'd1 << 5;
    localparam logic [25:0] M_INPORT  = 26'd1 << 6;
    localparam logic [25:0] M_COUT    = 26'd1 << 7;
    localparam logic [25:0] M_BAOUT   = 26'd1 << 8;
    localparam logic [25:0] M_MARIN   = 26'd1 << 9;
    localparam logic [25:0] M_MDRIN   = 26'd1 << 10;
    localparam logic [25:0] M_IRIN    = 26'd1 << 11;
    localparam logic [25:0] M_YIN     = 26'd1 << 12;
    localparam logic [25:0] M_ZIN     = 26'd1 << 13;
    localparam logic [25:0] M_PCIN    = 26'd1 << 14;
    localparam logic [25:0] M_CONIN   = 26'd1 << 17;
    localparam logic [25:0] M_OUTPIN  = 26'd1 << 18;
    localparam logic [25:0] M_RIN     = 26'd1 << 19;
    localparam logic [25:0] M_GRA     = 26'd1 << 20;
    localparam logic [25:0] M_GRB     = 26'd1 << 21;
    localparam logic [25:0] M_GRC     = 26'd1 << 22;
    localparam logic [25:0] M_ROUT    = 26'd1 << 23;
    localparam logic [25:0] M_READ    = 26'd1 << 24;
    localparam logic [25:0] M_WRITE   = 26'd1 << 25;
    localparam logic [25:0] M_SRC     = M_PCOUT | M_ZLOW | M_ZHIGH | M_MDROUT | M_HIOUT |
                                        M_LOOUT | M_INPORT | M_COUT | M_BAOUT | M_ROUT;

    wire [25:0] obs_mask = {Write, Read, Rout, Grc, Grb, Gra, Rin, OutportIn, CONin, LOin, HIin,
                            PCin, Zin, Yin, IRin, MDRin, MARin, BAout, Cout, InPortout, LOout,
                            HIout, MDRout, Zhighout, Zlowout, PCout};
    wire [31:0] obs = {run, ALU_Control, obs_mask};

    logic [31:0] exp_q[$];

    function automatic logic [31:0] step(input logic [25:0] m, input logic [4:0] alu);
        return {1'b1, alu, m};
    endfunction

    function automatic logic [31:0] fetch_t0();
        return step(M_PCOUT | M_MARIN | M_ZIN, 5'd12);
    endfunction

    // Reference model: the full list of per-cycle control words of one instruction, from T0.
    task automatic build_seq(input logic [4:0] op, input logic con);
        exp_q.delete();
        exp_q.push_back(fetch_t0());
        exp_q.push_back(step(M_ZLOW | M_PCIN | M_READ | M_MDRIN, 5'd0));
        exp_q.push_back(step(M_MDROUT | M_IRIN, 5'd0));
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(step(M_GRB | M_ROUT | M_YIN, 5'd0));
                exp_q.push_back(step(M_GRC | M_ROUT | M_ZIN,
                                     (op == 5'd3) ? 5'd2 : (op == 5'd4) ? 5'd3 :
                                     (op == 5'd5) ? 5'd4 : 5'd5));
                exp_q.push_back(step(M_ZLOW | M_GRA | M_RIN, 5'd0));
            end
            5'd11, 5'd12, 5'd13: begin
                exp_q.push_back(step(M_GRB | M_ROUT | M_YIN, 5'd0));
                exp_q.push_back(step(M_COUT | M_ZIN,
                                     (op == 5'd11) ? 5'd2 : (op == 5'd12) ? 5'd4 : 5'd5));
                exp_q.push_back(step(M_ZLOW | M_GRA | M_RIN, 5'd0));
            end
            5'd0, 5'd1, 5'd2: begin
                exp_q.push_back(step(M_GRB | M_BAOUT | M_YIN, 5'd0));
                exp_q.push_back(step(M_COUT | M_ZIN, 5'd2));
                if (op == 5'd1) begin
                    exp_q.push_back(step(M_ZLOW | M_GRA | M_RIN, 5'd0));
                end else begin
                    exp_q.push_back(step(M_ZLOW | M_MARIN, 5'd0));
                    if (op == 5'd0) begin
                        exp_q.push_back(step(M_READ | M_MDRIN, 5'd0));
                        exp_q.push_back(step(M_MDROUT | M_GRA | M_RIN, 5'd0));
                    end else begin
                        exp_q.push_back(step(M_GRA | M_ROUT | M_MDRIN, 5'd0));
                        exp_q.push_back(step(M_WRITE, 5'd0));
                    end
                end
            end
            5'd19: begin
                exp_q.push_back(step(M_GRA | M_ROUT | M_CONIN, 5'd0));
                exp_q.push_back(step(M_PCOUT | M_YIN, 5'd0));
                exp_q.push_back(step(M_COUT | M_ZIN, 5'd2));
                exp_q.push_back(step(con ? (M_ZLOW | M_PCIN) : 26'd0, 5'd0));
            end
            5'd20: exp_q.push_back(step(M_GRA | M_ROUT | M_PCIN, 5'd0));
            5'd21: begin
                exp_q.push_back(step(M_PCOUT | M_GRB | M_RIN, 5'd0));
                exp_q.push_back(step(M_GRA | M_ROUT | M_PCIN, 5'd0));
            end
            5'd22: exp_q.push_back(step(M_INPORT | M_GRA | M_RIN, 5'd0));
            5'd23: exp_q.push_back(step(M_GRA | M_ROUT | M_OUTPIN, 5'd0));
            5'd24: exp_q.push_back(step(M_HIOUT | M_GRA | M_RIN, 5'd0));
            5'd25: exp_q.push_back(step(M_LOOUT | M_GRA | M_RIN, 5'd0));
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 32'h0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, 32'h0);
            end
        end
        clr = 1'b1;
        tick();
        checks++;
        if (obs !== fetch_t0()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, fetch_t0());
        end
    endtask

    // Runs one non-halt instruction from T0 and checks every cycle plus the return to T0.
    task automatic test_sequence(input string name, input logic [31:0] instr, input logic con);
        ir     = instr;
        con_ff = con;
        build_seq(instr[31:27], con);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL %s op=%0d step T%0d: got %h expected %h",
                         name, instr[31:27], i, obs, exp_q[i]);
            end
            checks++;
            if ($countones(obs_mask & M_SRC) > 1 || (Read && Write)) begin
                errors++;
                $display("FAIL %s exclusivity op=%0d step T%0d: got mask %h expected at most one source/strobe",
                         name, instr[31:27], i, obs_mask);
            end
            tick();
        end
        checks++;
        if (obs !== fetch_t0()) begin
            errors++;
            $display("FAIL %s return_to_T0 op=%0d: got %h expected %h",
                     name, instr[31:27], obs, fetch_t0());
        end
    endtask

    task automatic test_branch();
        test_sequence("br_taken", 32'h9B000019, 1'b1);
        test_sequence("br_not_taken", 32'h9B000019, 1'b0);
    endtask

    task automatic test_ld();
        test_sequence("ld", 32'h00800045, 1'b0);
    endtask

    task automatic test_halt();
        ir = 32'hD8000000;
        build_seq(5'd27, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL halt_fetch step T%0d: got %h expected %h", i, obs, exp_q[i]);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (obs !== 32'h0) begin
                errors++;
                $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, 32'h0);
            end
            tick();
        end
        clr = 1'b0;
        tick();
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: got %h expected %h", obs, 32'h0);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (obs !== fetch_t0()) begin
            errors++;
            $display("FAIL halt_restart: got %h expected %h", obs, fetch_t0());
        end
    endtask

    // Abort an instruction after a chosen step; the following cycle must be fully idle.
    task automatic test_mid_reset(input logic [31:0] instr, input int stop_at);
        ir     = instr;
        con_ff = 1'b1;
        build_seq(instr[31:27], 1'b1);
        for (int i = 0; i <= stop_at; i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_reset op=%0d step T%0d: got %h expected %h",
                         instr[31:27], i, obs, exp_q[i]);
            end
            if (i < stop_at) tick();
        end
        clr = 1'b0;
        tick();
        checks++;
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_abort op=%0d at T%0d: got %h expected %h",
                     instr[31:27], stop_at, obs, 32'h0);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (obs !== fetch_t0()) begin
            errors++;
            $display("FAIL mid_reset_restart: got %h expected %h", obs, fetch_t0());
        end
    endtask

    task automatic test_random_mid_reset();
        logic [4:0] ops[6];
        logic [4:0] op;
        ops[0] = 5'd0; ops[1] = 5'd2; ops[2] = 5'd19;
        ops[3] = 5'd3; ops[4] = 5'd21; ops[5] = 5'd12;
        for (int n = 0; n < 12; n++) begin
            op = ops[$urandom_range(0, 5)];
            build_seq(op, 1'b1);
            test_mid_reset({op, 27'($urandom)}, int'($urandom_range(1, exp_q.size() - 1)));
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        for (int n = 0; n < 80; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            test_sequence("random", {op, 27'($urandom)}, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_ld();
        test_mid_reset(32'h10800045, 6);
        test_back_to_back();
        test_random_mid_reset();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
